// File: rtl/and_op_arbiter_pkg.sv
// Shared definitions for the two-requester AND arbiter.
//   state_e  : arbiter FSM states (IDLE, COMPUTE, RESP)
//   REQ_ID0/1: requester identifiers, also used as round-robin pointer values
package and_op_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_RESP    = 2'd2
  } state_e;

  localparam logic REQ_ID0 = 1'b0;
  localparam logic REQ_ID1 = 1'b1;

endpackage

// File: rtl/and_op_datapath.sv
// Shared compute resource: registered WIDTH-bit AND with load enable.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   load       : capture a & b into y on the next rising edge
//   clear      : return y to zero (takes priority over load)
//   a, b       : operands
//   y          : registered result
module and_op_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] y_q, y_d;

  always_comb begin
    y_d = y_q;
    if (clear) begin
      y_d = '0;
    end else if (load) begin
      y_d = a & b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      y_q <= '0;
    end else begin
      y_q <= y_d;
    end
  end

  assign y = y_q;

endmodule

// File: rtl/and_op_arbiter.sv
// Round-robin arbiter between two requesters sharing one registered AND unit.
// One transaction in flight: IDLE (grant/accept) -> COMPUTE -> RESP (hold
// until consumer takes the result) -> IDLE.
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   reqN_valid/reqN_a/reqN_b        : requester N operand pair
//   reqN_ready                      : requester N accepted when high with valid
//   rsp_valid/rsp_y/rsp_id          : result, y = a & b, id of served requester
//   rsp_ready                       : consumer accepts result
//   busy                            : high whenever not IDLE
//   grant_cnt0/grant_cnt1           : saturating per-requester accept counters,
//                                     present only with AND_OP_ARBITER_STATS_EN
module and_op_arbiter
  import and_op_arbiter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_y,
  output logic             rsp_id,
  input  logic             rsp_ready,
  output logic             busy
`ifdef AND_OP_ARBITER_STATS_EN
  ,
  output logic [7:0]       grant_cnt0,
  output logic [7:0]       grant_cnt1
`endif
);

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             id_q, id_d;
  logic             rsp_id_q, rsp_id_d;

  logic grant0, grant1;
  logic accept0, accept1;
  logic rsp_hs;

  // A lone requester always wins; on contention the pointer decides.
  assign grant0 = req0_valid & (~req1_valid | (ptr_q == REQ_ID0));
  assign grant1 = req1_valid & (~req0_valid | (ptr_q == REQ_ID1));

  // Gated by reset so no handshake can be seen during the reset cycle.
  assign req0_ready = (state_q == ST_IDLE) & grant0 & ~reset;
  assign req1_ready = (state_q == ST_IDLE) & grant1 & ~reset;

  assign accept0 = req0_valid & req0_ready;
  assign accept1 = req1_valid & req1_ready;
  assign rsp_hs  = (state_q == ST_RESP) & rsp_ready;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    a_d      = a_q;
    b_d      = b_q;
    id_d     = id_q;
    rsp_id_d = rsp_id_q;
    case (state_q)
      ST_IDLE: begin
        if (accept0) begin
          a_d     = req0_a;
          b_d     = req0_b;
          id_d    = REQ_ID0;
          ptr_d   = REQ_ID1;
          state_d = ST_COMPUTE;
        end else if (accept1) begin
          a_d     = req1_a;
          b_d     = req1_b;
          id_d    = REQ_ID1;
          ptr_d   = REQ_ID0;
          state_d = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        rsp_id_d = id_q;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          // Result fields return to their idle values once delivered.
          rsp_id_d = REQ_ID0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= REQ_ID0;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= REQ_ID0;
      rsp_id_q <= REQ_ID0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      id_q     <= id_d;
      rsp_id_q <= rsp_id_d;
    end
  end

  and_op_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk  (clk),
    .reset(reset),
    .load (state_q == ST_COMPUTE),
    .clear(rsp_hs),
    .a    (a_q),
    .b    (b_q),
    .y    (rsp_y)
  );

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_id    = rsp_id_q;
  assign busy      = (state_q != ST_IDLE);

`ifdef AND_OP_ARBITER_STATS_EN
  logic [7:0] cnt0_q, cnt0_d;
  logic [7:0] cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (accept0 && (cnt0_q != 8'hFF)) cnt0_d = cnt0_q + 8'd1;
    if (accept1 && (cnt1_q != 8'hFF)) cnt1_d = cnt1_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt0_q <= 8'd0;
      cnt1_q <= 8'd0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_and_op_arbiter.sv
// Self-checking bench for and_op_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_and_op_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic       req0_ready, req1_ready;
  logic       rsp_valid;
  logic [7:0] rsp_y;
  logic       rsp_id;
  logic       rsp_ready;
  logic       busy;
`ifdef AND_OP_ARBITER_STATS_EN
  logic [7:0] grant_cnt0, grant_cnt1;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  and_op_arbiter #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req0_valid(req0_valid),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .req1_ready(req1_ready),
    .rsp_valid (rsp_valid),
    .rsp_y     (rsp_y),
    .rsp_id    (rsp_id),
    .rsp_ready (rsp_ready),
    .busy      (busy)
`ifdef AND_OP_ARBITER_STATS_EN
    ,
    .grant_cnt0(grant_cnt0),
    .grant_cnt1(grant_cnt1)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 8'h00; req0_b = 8'h00; req1_a = 8'h00; req1_b = 8'h00;
    rsp_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 8'hFF; req0_b = 8'hFF; req1_a = 8'hFF; req1_b = 8'hFF;
    rsp_ready = 1'b1;
    tick();
    @(negedge clk);
    tests_run++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_cycle: ready0=%b ready1=%b busy=%b rsp_valid=%b, required all 0",
               req0_ready, req1_ready, busy, rsp_valid);
    end
    tick();
    reset = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests_run++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL idle_after_reset[%0d]: rsp_valid=%b busy=%b ready0=%b ready1=%b, required all 0",
                 i, rsp_valid, busy, req0_ready, req1_ready);
      end
      tick();
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_single;
    do_reset();
    req0_valid = 1'b1; req0_a = 8'hF0; req0_b = 8'h3C; rsp_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_accept: ready0=%b ready1=%b, required 1/0", req0_ready, req1_ready);
    end
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_n1: rsp_valid=%b busy=%b, required 0/1", rsp_valid, busy);
    end
    tick();
    @(negedge clk);
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_y !== 8'h30 || rsp_id !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_n2: rsp_valid=%b y=%h id=%b, required 1/30/0", rsp_valid, rsp_y, rsp_id);
    end
    tick();
    @(negedge clk);
    tests_run++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_done: rsp_valid=%b busy=%b, required 0/0", rsp_valid, busy);
    end
    $display("[TB] test_single done");
  endtask

  task automatic test_alternate;
    int n;
    int exp_id;
    logic [7:0] exp_y;
    reset = 1'b1;
    req0_valid = 1'b1; req0_a = 8'hFF; req0_b = 8'h0F;
    req1_valid = 1'b1; req1_a = 8'hAA; req1_b = 8'hFF;
    rsp_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        exp_id = n % 2;
        exp_y  = (exp_id == 1) ? 8'hAA : 8'h0F;
        tests_run++;
        if (rsp_id !== exp_id[0] || rsp_y !== exp_y) begin
          tests_failed++;
          $display("FAIL alternate[%0d]: id=%b y=%h, required %0d/%h", n, rsp_id, rsp_y, exp_id, exp_y);
        end
        n++;
      end
      tick();
    end
    tests_run++;
    if (n != 4) begin
      tests_failed++;
      $display("FAIL alternate_count: got %0d responses, required 4", n);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    $display("[TB] test_alternate done");
  endtask

  task automatic test_backpressure;
    bit found;
    do_reset();
    req1_valid = 1'b1; req1_a = 8'h5A; req1_b = 8'hF0;
    rsp_ready = 1'b0;
    tick();
    req0_valid = 1'b1; req0_a = 8'h11; req0_b = 8'h22;
    found = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("FAIL backpressure_timeout: rsp_valid=0, required 1 within 6 cycles");
    end
    for (int k = 0; k < 5; k++) begin
      tests_run++;
      if (rsp_valid !== 1'b1 || rsp_y !== 8'h50 || rsp_id !== 1'b1 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL backpressure_hold[%0d]: v=%b y=%h id=%b r0=%b r1=%b busy=%b, required 1/50/1/0/0/1",
                 k, rsp_valid, rsp_y, rsp_id, req0_ready, req1_ready, busy);
      end
      tick();
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    tick();
    @(negedge clk);
    // Pointer moved to requester 0 after serving requester 1.
    tests_run++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL backpressure_release: busy=%b v=%b r0=%b r1=%b, required 0/0/1/0",
               busy, rsp_valid, req0_ready, req1_ready);
    end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    $display("[TB] test_backpressure done");
  endtask

  task automatic test_reset_mid;
    bit found;
    do_reset();
    req0_valid = 1'b1; req0_a = 8'hFF; req0_b = 8'hFF; rsp_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (req0_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL resetmid_accept: ready0=%b, required 1", req0_ready);
    end
    tick();
    req0_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests_run++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL resetmid_discard[%0d]: rsp_valid=%b busy=%b, required 0/0", k, rsp_valid, busy);
      end
      tick();
    end
    req1_valid = 1'b1; req1_a = 8'h55; req1_b = 8'h0F;
    tick();
    req1_valid = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    tests_run++;
    if (!found || rsp_y !== 8'h05 || rsp_id !== 1'b1) begin
      tests_failed++;
      $display("FAIL resetmid_next: found=%b y=%h id=%b, required 1/05/1", found, rsp_y, rsp_id);
    end
    tick();
    $display("[TB] test_reset_mid done");
  endtask

  // Reference model: a transaction is accepted from an idle arbiter by the
  // round-robin rule, its result shows up two cycles later and is held until
  // the consumer takes it; the following cycle the arbiter is idle again.
  task automatic test_random;
    int         m_ptr;
    bit         m_busy;
    int         m_acc;
    logic [7:0] m_y;
    logic       m_id;
    int         w;
    bit         e_r0, e_r1, e_rv;
    int         errs;
    do_reset();
    m_ptr = 0; m_busy = 1'b0; m_acc = 0; m_y = 8'h00; m_id = 1'b0;
    errs = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      req0_valid = ($urandom_range(0, 2) != 0);
      req1_valid = ($urandom_range(0, 2) != 0);
      req0_a = 8'($urandom); req0_b = 8'($urandom);
      req1_a = 8'($urandom); req1_b = 8'($urandom);
      rsp_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      w = -1;
      if (!m_busy) begin
        if (req0_valid && req1_valid) w = m_ptr;
        else if (req0_valid) w = 0;
        else if (req1_valid) w = 1;
      end
      e_r0 = (w == 0);
      e_r1 = (w == 1);
      e_rv = m_busy && (cyc - m_acc >= 2);
      tests_run++;
      if (req0_ready !== e_r0 || req1_ready !== e_r1 || rsp_valid !== e_rv || busy !== m_busy ||
          (e_rv && (rsp_y !== m_y || rsp_id !== m_id))) begin
        tests_failed++;
        errs++;
        if (errs <= 10)
          $display("FAIL random[%0d]: r0=%b r1=%b v=%b busy=%b y=%h id=%b, required %b/%b/%b/%b/%h/%b",
                   cyc, req0_ready, req1_ready, rsp_valid, busy, rsp_y, rsp_id,
                   e_r0, e_r1, e_rv, m_busy, m_y, m_id);
      end
      if (w == 0) begin
        m_busy = 1'b1; m_acc = cyc; m_y = req0_a & req0_b; m_id = 1'b0; m_ptr = 1;
      end else if (w == 1) begin
        m_busy = 1'b1; m_acc = cyc; m_y = req1_a & req1_b; m_id = 1'b1; m_ptr = 0;
      end else if (e_rv && rsp_ready) begin
        m_busy = 1'b0;
      end
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    $display("[TB] test_random done, %0d cycle mismatches", errs);
  endtask

`ifdef AND_OP_ARBITER_STATS_EN
  task automatic test_stats;
    int grants;
    do_reset();
    req1_valid = 1'b1; req1_a = 8'h0F; req1_b = 8'hF0; rsp_ready = 1'b1;
    grants = 0;
    for (int c = 0; c < 1200 && grants < 300; c++) begin
      @(negedge clk);
      if (req1_valid && req1_ready) grants++;
      tick();
    end
    req1_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (grants != 300 || grant_cnt1 !== 8'd255 || grant_cnt0 !== 8'd0) begin
      tests_failed++;
      $display("FAIL stats_saturate: grants=%0d cnt1=%0d cnt0=%0d, required 300/255/0",
               grants, grant_cnt1, grant_cnt0);
    end
    tick();
    $display("[TB] test_stats done");
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_backpressure();
    test_reset_mid();
    test_random();
`ifdef AND_OP_ARBITER_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
